uart_tx_arbiter: RTL and testbench

//  Shares one uart_send transmitter among N_REQ byte requesters with round-robin fairness.

---
 rtl/uart_tx_arbiter.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding a single uart_send transmitter
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int BUSY_TIMEOUT = 16,
    localparam int GW          = $clog2(N_REQ),
    localparam int CW          = $clog2(BUSY_TIMEOUT + 1)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ack,
    input  logic                 tx_busy,
    output logic                 send_en,
    output logic [7:0]           send_data,
    output logic [GW-1:0]        grant_id,
    output logic                 err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [N_REQ-1:0]     r_req_ack;
    logic                 r_send_en;
    logic [7:0]           r_send_data;
    logic [GW-1:0]        r_grant_id;
    logic [GW-1:0]        r_last_grant;
    logic                 r_err_timeout;
    logic [CW-1:0]        r_cnt;

    logic [N_REQ-1:0]     w_req_ack_nxt;
    logic                 w_send_en_nxt;
    logic [7:0]           w_send_data_nxt;
    logic [GW-1:0]        w_grant_id_nxt;
    logic [GW-1:0]        w_last_grant_nxt;
    logic                 w_err_timeout_nxt;
    logic [CW-1:0]        w_cnt_nxt;

    logic [7:0]           w_bytes [N_REQ];
    logic                 w_found;
    logic [GW-1:0]        w_pick;
    logic                 w_grant;
    logic                 w_timeout;

    // Unpack the flat request byte bus into one byte per requester
    for (genvar g = 0; g < N_REQ; g++) begin : g_bytes
        assign w_bytes[g] = req_data[8*g +: 8];
    end

    // Round-robin search starting just after the last grant; iterating from the
    // farthest candidate down leaves the nearest set request as the winner
    always_comb begin
        logic [GW:0] v_sum;
        w_found = 1'b0;
        w_pick  = '0;
        v_sum   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            v_sum = {1'b0, r_last_grant} + (GW+1)'(k);
            if (v_sum >= (GW+1)'(N_REQ)) begin
                v_sum = v_sum - (GW+1)'(N_REQ);
            end
            if (req[v_sum[GW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = v_sum[GW-1:0];
            end
        end
    end

    assign w_grant   = (r_state == ST_IDLE) && !tx_busy && w_found;
    assign w_timeout = (r_cnt == CW'(BUSY_TIMEOUT - 1));

    // State register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; ack and timeout default to a single-cycle pulse
    always_comb begin
        w_req_ack_nxt     = '0;
        w_err_timeout_nxt = 1'b0;
        w_send_en_nxt     = r_send_en;
        w_send_data_nxt   = r_send_data;
        w_grant_id_nxt    = r_grant_id;
        w_last_grant_nxt  = r_last_grant;
        w_cnt_nxt         = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_send_data_nxt  = w_bytes[w_pick];
                    w_grant_id_nxt   = w_pick;
                    w_last_grant_nxt = w_pick;
                    w_req_ack_nxt    = N_REQ'(1) << w_pick;
                    w_send_en_nxt    = 1'b1;
                    w_cnt_nxt        = '0;
                end
            end
            ST_ISSUE: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (tx_busy) begin
                    w_send_en_nxt = 1'b0;
                end else if (w_timeout) begin
                    // The byte was already acked, so it is dropped here
                    w_send_en_nxt     = 1'b0;
                    w_err_timeout_nxt = 1'b1;
                end
            end
            default: begin
                w_send_en_nxt = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_req_ack     <= '0;
            r_send_en     <= 1'b0;
            r_send_data   <= '0;
            r_grant_id    <= '0;
            r_last_grant  <= GW'(N_REQ - 1);
            r_err_timeout <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_req_ack     <= w_req_ack_nxt;
            r_send_en     <= w_send_en_nxt;
            r_send_data   <= w_send_data_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_last_grant  <= w_last_grant_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign req_ack     = r_req_ack;
    assign send_en     = r_send_en;
    assign send_data   = r_send_data;
    assign grant_id    = r_grant_id;
    assign err_timeout = r_err_timeout;

    // Structural invariants: at most one ack bit, and send_en only while issuing
    a_ack_onehot: assert property (@(posedge sys_clk) disable iff (sys_rst) $onehot0(r_req_ack));
    a_en_in_issue: assert property (@(posedge sys_clk) disable iff (sys_rst) r_send_en |-> (r_state == ST_ISSUE));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           sys_clk  = 1'b0;
    logic           sys_rst  = 1'b1;
    logic [N-1:0]   req      = '0;
    logic [8*N-1:0] req_data = '0;
    logic           tx_busy  = 1'b0;
    logic [N-1:0]   req_ack;
    logic           send_en;
    logic [7:0]     send_data;
    logic [1:0]     grant_id;
    logic           err_timeout;

    int n_checks = 0;
    int n_errors = 0;
    int m_last   = N - 1;

    uart_tx_arbiter #(.N_REQ(N), .BUSY_TIMEOUT(TO)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_busy     (tx_busy),
        .send_en     (send_en),
        .send_data   (send_data),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"},   32'(req_ack),     32'h0);
        check_eq({tag, "_en"},    32'(send_en),     32'h0);
        check_eq({tag, "_data"},  32'(send_data),   32'h0);
        check_eq({tag, "_gid"},   32'(grant_id),    32'h0);
        check_eq({tag, "_err"},   32'(err_timeout), 32'h0);
    endtask

    // Present a request vector in IDLE and check the grant one edge later
    task automatic grant_step(input logic [N-1:0] v, input logic [8*N-1:0] d,
                              input bit drop, output logic [7:0] exp_b);
        int exp_i;
        req      = v;
        req_data = d;
        @(negedge sys_clk);
        exp_i = rr_pick(m_last, v);
        exp_b = d[8*exp_i +: 8];
        check_eq("grant_ack",  32'(req_ack),   32'(1) << exp_i);
        check_eq("grant_en",   32'(send_en),   32'h1);
        check_eq("grant_data", 32'(send_data), 32'(exp_b));
        check_eq("grant_id",   32'(grant_id),  32'(exp_i));
        m_last = exp_i;
        if (drop) req = '0;
    endtask

    // Transmitter model: reports busy some cycles after en, for a few cycles
    task automatic finish_normal(input logic [7:0] exp_b);
        int d;
        int l;
        d = $urandom_range(0, 8);
        for (int i = 0; i < d; i++) begin
            @(negedge sys_clk);
            check_eq("issue_en_hold", 32'(send_en), 32'h1);
            check_eq("issue_ack_clr", 32'(req_ack), 32'h0);
        end
        tx_busy = 1'b1;
        @(negedge sys_clk);
        check_eq("wait_en_low", 32'(send_en),     32'h0);
        check_eq("wait_ack",    32'(req_ack),     32'h0);
        check_eq("wait_err",    32'(err_timeout), 32'h0);
        l = $urandom_range(1, 6);
        for (int i = 0; i < l; i++) begin
            @(negedge sys_clk);
            check_eq("wait_data_hold", 32'(send_data), 32'(exp_b));
        end
        tx_busy = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic finish_timeout();
        int cnt;
        int early;
        cnt   = 0;
        early = 0;
        while (send_en === 1'b1 && cnt < 40) begin
            cnt++;
            if (err_timeout !== 1'b0) early++;
            @(negedge sys_clk);
        end
        check_eq("to_len",   32'(cnt),         32'(TO));
        check_eq("to_early", 32'(early),       32'h0);
        check_eq("to_err",   32'(err_timeout), 32'h1);
        @(negedge sys_clk);
        check_eq("to_err_clr", 32'(err_timeout), 32'h0);
    endtask

    initial begin
        logic [7:0]     b;
        logic [N-1:0]   v;
        logic [8*N-1:0] d;

        repeat (3) @(negedge sys_clk);
        check_reset_outputs("rst");
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Single byte from requester 2
        grant_step(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00}, 1'b1, b);
        finish_normal(b);

        // Fairness with every request held high
        d = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 8; i++) begin
            grant_step(4'b1111, d, 1'b0, b);
            finish_normal(b);
        end
        req = '0;

        // Transmitter never reports busy
        grant_step(4'b0010, {$urandom, $urandom}, 1'b1, b);
        finish_timeout();

        // Transmitter still draining in IDLE blocks the grant
        tx_busy = 1'b1;
        req     = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check_eq("prebusy_ack", 32'(req_ack), 32'h0);
            check_eq("prebusy_en",  32'(send_en), 32'h0);
        end
        tx_busy = 1'b0;
        grant_step(4'b0001, {$urandom, $urandom}, 1'b1, b);
        finish_normal(b);

        // Reset during WAIT_DONE with requester 3 pending
        grant_step(4'b1000, {$urandom, $urandom}, 1'b1, b);
        tx_busy = 1'b1;
        @(negedge sys_clk);
        req     = 4'b1000;
        sys_rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        m_last  = N - 1;
        tx_busy = 1'b0;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        grant_step(4'b1000, {$urandom, $urandom}, 1'b1, b);
        finish_normal(b);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        m_last  = N - 1;
        sys_rst = 1'b0;
        grant_step(4'b1001, {$urandom, $urandom}, 1'b1, b);
        check_eq("rst_first_grant", 32'(grant_id), 32'h0);
        finish_normal(b);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            d = {$urandom, $urandom};
            grant_step(v, d, 1'b1, b);
            if ($urandom_range(0, 4) == 0) begin
                finish_timeout();
            end else begin
                finish_normal(b);
            end
            if ($urandom_range(0, 2) == 0) begin
                @(negedge sys_clk);
                check_eq("idle_no_ack", 32'(req_ack), 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
